ocx_tlx_tx_bdi_pack: RTL and testbench
======================================

Name: ocx_tlx_tx_bdi_pack

Overview:
Transmit-side bad-data-indicator packer for the TLX framer path. It captures one BDI bit per 64B beat as AFU response data (VC0) and AFU command data (VC1) are accepted. It releases those bits in the order the data arbiter schedules data flits. On each control flit it supplies the 8-bit bad_data_indicator field that covers the run_length data flits preceding that control flit.

Parameters:
resp_addr_width, 6, log2 depth of VC0 (response data) BDI FIFO
cmd_addr_width, 6, log2 depth of VC1 (command data) BDI FIFO

Ports:
tlx_clk  in  1  clock
reset_n  in  1  synchronous active-low reset
afu_tlx_resp_data_valid  in  1  VC0 64B beat accepted this cycle
afu_tlx_resp_data_bdi  in  1  BDI for that VC0 beat
afu_tlx_cmd_data_valid  in  1  VC1 64B beat accepted this cycle
afu_tlx_cmd_data_bdi  in  1  BDI for that VC1 beat
data_arb_vc_v  in  2  one-hot grant; bit0=VC0, bit1=VC1
data_arb_flit_cnt  in  2  flits granted: 01=1, 10=2, 11=4, 00=none
ctl_flit_req  in  1  framer building control flit
run_length  in  4  data flits covered by this control flit, 0..8
tlx_bdi_v  out  1  bad_data_indicator valid, 1 cycle after ctl_flit_req
tlx_bad_data_indicator  out  8  bit k = BDI of k-th pending data flit
resp_bdi_fifo_full  out  1  VC0 FIFO full
cmd_bdi_fifo_full  out  1  VC1 FIFO full
bdi_err  out  1  sticky protocol-error flag

Behaviour:
- Reset: tlx_clk and reset_n (synchronous, active-low). Clears all pointers and counts, the accumulator and every output to 0. Fifo_full outputs read 0 after reset. FIFO array contents are not reset.
- Each FIFO: wr/rd pointers one bit wider than addr, so full/empty are exact. count = wr - rd.
- FIFO write: on *_data_valid, store bdi at wr_ptr and increment wr_ptr by 1.
- Write when full: drop the bit, leave wr_ptr unchanged, set bdi_err.
- Grant: in cycle N, data_arb_vc_v (with flit_cnt != 00) selects one FIFO. n = 1/2/4 oldest bits are read combinationally from rd_ptr..rd_ptr+n-1, with pointer wrap modulo depth.
  - rd_ptr advances by min(n, count).
  - Missing entries (count < n) are supplied as 1 (poison) and set bdi_err.
  - Both vc_v bits set: ignore the grant and set bdi_err.
  - Same-cycle write and read on one FIFO are both legal. Full/empty reflect both.
- Accumulator: 16-bit acc plus 5-bit acc_cnt (0..16). The oldest flit is in bit 0.
  - Granted bits append at positions acc_cnt.. and become visible in cycle N+1.
- Control flit: on ctl_flit_req in cycle N with r = run_length:
  - Registered output in cycle N+1: tlx_bdi_v=1, tlx_bad_data_indicator[k] = acc[k] for k<r, 0 for k>=r.
  - acc shifts right by r and acc_cnt decreases by r.
  - r > acc_cnt: missing bits (k in acc_cnt..r-1) read 1, acc_cnt goes to 0, bdi_err set.
  - r > 8: clamp to 8 and set bdi_err.
  - r = 0: output 8'h00, valid still pulses.
- Same-cycle request and grant: the request consumes from the acc state at cycle start. New bits append after the shift, i.e. at position acc_cnt - r (floored at 0).
- Accumulator overflow (acc_cnt - r + n > 16): drop the excess newest bits and set bdi_err.
- tlx_bdi_v is a 1-cycle pulse per request. Back-to-back requests are allowed every cycle.
- bdi_err: sticky, cleared only by reset.
- Reset mid-operation: all in-flight BDI bits are discarded and no tlx_bdi_v is issued.

Decomposition:
- Package ocx_tlx_bdi_pkg: flit_cnt decode constants (01→1, 10→2, 11→4), ACC_W=16, BDI_W=8, MAX_RUN=8.
- One sub-module, ocx_tlx_bdi_fifo: parameterized 1-bit-wide FIFO with 1-write/up-to-4-read per cycle, full/empty/count, and poison-fill on underflow. Instantiated twice, once per VC.

Test Plan:
- VC0 beats bdi 1,0,1 -> grant VC0 cnt=10 (2) -> ctl_flit_req rl=2 -> next cycle tlx_bdi_v=1, indicator=8'h01. acc_cnt=0; VC0 FIFO holds one entry.
- VC1 beats 0,0,1,1 and VC0 beat 1; grant VC1 cnt=11 (4), then VC0 cnt=01 -> ctl rl=5 -> indicator=8'h1C.
- Empty VC0 FIFO, grant cnt=10 -> ctl rl=2 -> indicator=8'h03, bdi_err=1 (sticky through later traffic).
- Write 2^resp_addr_width beats with no grant -> resp_bdi_fifo_full=1. One more write -> dropped, bdi_err=1. Then grant 4 and write the same cycle -> full deasserts next cycle.
- Same-cycle: acc holds 3 bits 3'b110. ctl rl=2 together with grant VC1 cnt=01 (bit 1) -> indicator=8'h02. Next ctl rl=2 -> indicator=8'h03.
- Assert reset_n=0 for one cycle with 6 bits pending -> next ctl rl=0 -> indicator=8'h00, bdi_err=0, FIFOs empty.

Source files
------------

// File: rtl/ocx_tlx_bdi_pkg.sv
// Shared constants for the TLX transmit BDI packer: flit-count decode and
// accumulator/indicator widths.
package ocx_tlx_bdi_pkg;

  localparam int ACC_W   = 16;
  localparam int BDI_W   = 8;
  localparam int MAX_RUN = 8;

  localparam logic [1:0] FLIT_CNT_NONE = 2'b00;
  localparam logic [1:0] FLIT_CNT_1    = 2'b01;
  localparam logic [1:0] FLIT_CNT_2    = 2'b10;
  localparam logic [1:0] FLIT_CNT_4    = 2'b11;

  function automatic logic [2:0] flit_cnt_decode(input logic [1:0] cnt);
    case (cnt)
      FLIT_CNT_1: flit_cnt_decode = 3'd1;
      FLIT_CNT_2: flit_cnt_decode = 3'd2;
      FLIT_CNT_4: flit_cnt_decode = 3'd4;
      default:    flit_cnt_decode = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/ocx_tlx_bdi_fifo.sv
// 1-bit-wide BDI FIFO: one write and up to four combinational reads per cycle.
// Reads past the stored entries return 1 (poison).
module ocx_tlx_bdi_fifo #(
  parameter int ADDR_W = 6
) (
  input  logic              tlx_clk,
  input  logic              reset_n,
  input  logic              wr_v,
  input  logic              wr_bdi,
  input  logic [2:0]        rd_n,
  output logic [3:0]        rd_bits,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              wr_drop
);

  localparam int DEPTH = 1 << ADDR_W;

  logic                mem_q [DEPTH];
  logic [ADDR_W:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     rd_ptr_q, rd_ptr_d;
  logic [2:0]          rd_take;
  logic                wr_ok;

  // Pointers carry one extra bit, so count reaches DEPTH exactly when full.
  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = count[ADDR_W];

  always_comb begin
    rd_take = rd_n;
    if (count < (ADDR_W+1)'(rd_n)) rd_take = count[2:0];
    // A read in the same cycle frees a slot, so a write into a full FIFO is kept.
    wr_ok    = wr_v && (!full || rd_take != 3'd0);
    wr_drop  = wr_v && !wr_ok;
    wr_ptr_d = wr_ptr_q + (ADDR_W+1)'(wr_ok);
    rd_ptr_d = rd_ptr_q + (ADDR_W+1)'(rd_take);
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rd
      logic [ADDR_W-1:0] idx;
      assign idx         = rd_ptr_q[ADDR_W-1:0] + ADDR_W'(gi);
      assign rd_bits[gi] = (3'(gi) < rd_take) ? mem_q[idx] : 1'b1;
    end
  endgenerate

  always_ff @(posedge tlx_clk) begin
    if (wr_ok) mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_bdi;
  end

  always_ff @(posedge tlx_clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/ocx_tlx_tx_bdi_pack.sv
// Transmit BDI packer: queues per-VC BDI bits, orders them by data-flit grant,
// and emits the 8-bit bad_data_indicator for each control flit.
module ocx_tlx_tx_bdi_pack
  import ocx_tlx_bdi_pkg::*;
#(
  parameter int resp_addr_width = 6,
  parameter int cmd_addr_width  = 6
) (
  input  logic             tlx_clk,
  input  logic             reset_n,
  input  logic             afu_tlx_resp_data_valid,
  input  logic             afu_tlx_resp_data_bdi,
  input  logic             afu_tlx_cmd_data_valid,
  input  logic             afu_tlx_cmd_data_bdi,
  input  logic [1:0]       data_arb_vc_v,
  input  logic [1:0]       data_arb_flit_cnt,
  input  logic             ctl_flit_req,
  input  logic [3:0]       run_length,
  output logic             tlx_bdi_v,
  output logic [BDI_W-1:0] tlx_bad_data_indicator,
  output logic             resp_bdi_fifo_full,
  output logic             cmd_bdi_fifo_full,
  output logic             bdi_err
);

  logic [2:0]               grant_n, vc0_n, vc1_n, app_n;
  logic                     grant_conflict, rd_short;
  logic [3:0]               resp_bits, cmd_bits, app_bits;
  logic [resp_addr_width:0] resp_count;
  logic [cmd_addr_width:0]  cmd_count;
  logic                     resp_drop, cmd_drop;

  logic [ACC_W-1:0] acc_q, acc_d, acc_shift;
  logic [4:0]       acc_cnt_q, acc_cnt_d, cnt_base, cnt_sum, run;
  logic             run_ovr, run_short, acc_ovf;
  logic             bdi_v_q, bdi_v_d;
  logic [BDI_W-1:0] ind_q, ind_d;
  logic             err_q, err_d;

  always_comb begin
    grant_n        = flit_cnt_decode(data_arb_flit_cnt);
    grant_conflict = (data_arb_vc_v == 2'b11) && (grant_n != 3'd0);
    vc0_n          = (data_arb_vc_v == 2'b01) ? grant_n : 3'd0;
    vc1_n          = (data_arb_vc_v == 2'b10) ? grant_n : 3'd0;
    app_n          = vc0_n | vc1_n;
    app_bits       = (vc0_n != 3'd0) ? resp_bits : cmd_bits;
    rd_short       = ((vc0_n != 3'd0) && (resp_count < (resp_addr_width+1)'(vc0_n))) ||
                     ((vc1_n != 3'd0) && (cmd_count < (cmd_addr_width+1)'(vc1_n)));
  end

  ocx_tlx_bdi_fifo #(.ADDR_W(resp_addr_width)) u_resp_fifo (
    .tlx_clk (tlx_clk),
    .reset_n (reset_n),
    .wr_v    (afu_tlx_resp_data_valid),
    .wr_bdi  (afu_tlx_resp_data_bdi),
    .rd_n    (vc0_n),
    .rd_bits (resp_bits),
    .count   (resp_count),
    .full    (resp_bdi_fifo_full),
    .wr_drop (resp_drop)
  );

  ocx_tlx_bdi_fifo #(.ADDR_W(cmd_addr_width)) u_cmd_fifo (
    .tlx_clk (tlx_clk),
    .reset_n (reset_n),
    .wr_v    (afu_tlx_cmd_data_valid),
    .wr_bdi  (afu_tlx_cmd_data_bdi),
    .rd_n    (vc1_n),
    .rd_bits (cmd_bits),
    .count   (cmd_count),
    .full    (cmd_bdi_fifo_full),
    .wr_drop (cmd_drop)
  );

  // The request consumes from the cycle-start accumulator; granted bits then land after the shift.
  always_comb begin
    run_ovr   = ctl_flit_req && (run_length > 4'(MAX_RUN));
    run       = !ctl_flit_req ? 5'd0 : (run_ovr ? 5'(MAX_RUN) : {1'b0, run_length});
    run_short = run > acc_cnt_q;
    ind_d     = '0;
    for (int k = 0; k < BDI_W; k++) begin
      if (5'(k) < run) ind_d[k] = (5'(k) < acc_cnt_q) ? acc_q[k] : 1'b1;
    end
    acc_shift = acc_q >> run;
    cnt_base  = run_short ? 5'd0 : acc_cnt_q - run;
    acc_d     = acc_shift;
    acc_ovf   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < app_n) begin
        if ((cnt_base + 5'(i)) < 5'(ACC_W)) acc_d[4'(cnt_base + 5'(i))] = app_bits[i];
        else                                acc_ovf = 1'b1;
      end
    end
    cnt_sum   = cnt_base + {2'b00, app_n};
    acc_cnt_d = (cnt_sum > 5'(ACC_W)) ? 5'(ACC_W) : cnt_sum;
    bdi_v_d   = ctl_flit_req;
    err_d     = err_q | resp_drop | cmd_drop | rd_short | grant_conflict |
                run_ovr | run_short | acc_ovf;
  end

  always_ff @(posedge tlx_clk) begin
    if (!reset_n) begin
      acc_q     <= '0;
      acc_cnt_q <= '0;
      bdi_v_q   <= 1'b0;
      ind_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      acc_cnt_q <= acc_cnt_d;
      bdi_v_q   <= bdi_v_d;
      ind_q     <= ind_d;
      err_q     <= err_d;
    end
  end

  assign tlx_bdi_v              = bdi_v_q;
  assign tlx_bad_data_indicator = ind_q;
  assign bdi_err                = err_q;

endmodule

// File: tb/tb_ocx_tlx_tx_bdi_pack.sv
// Directed self-checking bench for the TLX transmit BDI packer.
module tb_ocx_tlx_tx_bdi_pack;

  logic       tlx_clk = 1'b0;
  logic       reset_n;
  logic       resp_v, resp_bdi, cmd_v, cmd_bdi;
  logic [1:0] vc_v, flit_cnt;
  logic       ctl;
  logic [3:0] rl;
  logic       bdi_v, resp_full, cmd_full, err;
  logic [7:0] ind;

  int checks = 0;
  int passed = 0;

  always #5 tlx_clk = ~tlx_clk;

  ocx_tlx_tx_bdi_pack #(.resp_addr_width(6), .cmd_addr_width(6)) dut (
    .tlx_clk                 (tlx_clk),
    .reset_n                 (reset_n),
    .afu_tlx_resp_data_valid (resp_v),
    .afu_tlx_resp_data_bdi   (resp_bdi),
    .afu_tlx_cmd_data_valid  (cmd_v),
    .afu_tlx_cmd_data_bdi    (cmd_bdi),
    .data_arb_vc_v           (vc_v),
    .data_arb_flit_cnt       (flit_cnt),
    .ctl_flit_req            (ctl),
    .run_length              (rl),
    .tlx_bdi_v               (bdi_v),
    .tlx_bad_data_indicator  (ind),
    .resp_bdi_fifo_full      (resp_full),
    .cmd_bdi_fifo_full       (cmd_full),
    .bdi_err                 (err)
  );

  // Inputs change right after a falling edge; outputs are sampled at falling edges.
  task automatic idle();
    resp_v = 0; resp_bdi = 0; cmd_v = 0; cmd_bdi = 0;
    vc_v = 2'b00; flit_cnt = 2'b00; ctl = 0; rl = 4'd0;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 0;
    @(negedge tlx_clk);
    @(negedge tlx_clk);
    reset_n = 1;
  endtask

  task automatic push0(input logic b);
    resp_v = 1; resp_bdi = b;
    @(negedge tlx_clk);
    resp_v = 0;
  endtask

  task automatic push1(input logic b);
    cmd_v = 1; cmd_bdi = b;
    @(negedge tlx_clk);
    cmd_v = 0;
  endtask

  task automatic grant(input logic [1:0] v, input logic [1:0] c);
    vc_v = v; flit_cnt = c;
    @(negedge tlx_clk);
    vc_v = 2'b00; flit_cnt = 2'b00;
  endtask

  task automatic ctl_req(input logic [3:0] r);
    ctl = 1; rl = r;
    @(negedge tlx_clk);
    ctl = 0; rl = 4'd0;
    $display("ctl rl=%0d -> v=%b ind=%h err=%b", r, bdi_v, ind, err);
  endtask

  task automatic test_reset();
    reset_n = 0; idle();
    @(negedge tlx_clk);
    @(negedge tlx_clk);
    reset_n = 1;
    checks++; if (bdi_v !== 1'b0) $display("FAIL reset_v got %b exp 0", bdi_v); else passed++;
    checks++; if (ind !== 8'h00) $display("FAIL reset_ind got %h exp 00", ind); else passed++;
    checks++; if (err !== 1'b0) $display("FAIL reset_err got %b exp 0", err); else passed++;
    checks++; if ({resp_full, cmd_full} !== 2'b00) $display("FAIL reset_full got %b exp 00", {resp_full, cmd_full}); else passed++;
  endtask

  task automatic test_basic();
    do_reset();
    push0(1); push0(0); push0(1);
    grant(2'b01, 2'b10);
    ctl_req(4'd2);
    checks++; if (bdi_v !== 1'b1) $display("FAIL basic_v got %b exp 1", bdi_v); else passed++;
    checks++; if (ind !== 8'h01) $display("FAIL basic_ind got %h exp 01", ind); else passed++;
    @(negedge tlx_clk);
    checks++; if (bdi_v !== 1'b0) $display("FAIL basic_pulse got %b exp 0", bdi_v); else passed++;
    grant(2'b01, 2'b01);
    ctl_req(4'd1);
    checks++; if (ind !== 8'h01) $display("FAIL basic_left_ind got %h exp 01", ind); else passed++;
    checks++; if (err !== 1'b0) $display("FAIL basic_err got %b exp 0", err); else passed++;
  endtask

  task automatic test_mixed();
    do_reset();
    push1(0); push1(0); push1(1); push1(1);
    push0(1);
    grant(2'b10, 2'b11);
    grant(2'b01, 2'b01);
    ctl_req(4'd5);
    checks++; if (bdi_v !== 1'b1) $display("FAIL mixed_v got %b exp 1", bdi_v); else passed++;
    checks++; if (ind !== 8'h1C) $display("FAIL mixed_ind got %h exp 1c", ind); else passed++;
    checks++; if (err !== 1'b0) $display("FAIL mixed_err got %b exp 0", err); else passed++;
  endtask

  task automatic test_underflow();
    do_reset();
    grant(2'b01, 2'b10);
    ctl_req(4'd2);
    checks++; if (ind !== 8'h03) $display("FAIL under_ind got %h exp 03", ind); else passed++;
    checks++; if (err !== 1'b1) $display("FAIL under_err got %b exp 1", err); else passed++;
    push0(0);
    grant(2'b01, 2'b01);
    ctl_req(4'd1);
    checks++; if (ind !== 8'h00) $display("FAIL under_next_ind got %h exp 00", ind); else passed++;
    checks++; if (err !== 1'b1) $display("FAIL under_sticky got %b exp 1", err); else passed++;
  endtask

  task automatic test_fifo_full();
    logic [6:0] i7;
    do_reset();
    for (int i = 0; i < 64; i++) begin
      i7 = 7'(i);
      push0(i7[0]);
    end
    checks++; if (resp_full !== 1'b1) $display("FAIL full_set got %b exp 1", resp_full); else passed++;
    checks++; if (err !== 1'b0) $display("FAIL full_err_pre got %b exp 0", err); else passed++;
    push0(1);
    checks++; if (err !== 1'b1) $display("FAIL full_drop_err got %b exp 1", err); else passed++;
    resp_v = 1; resp_bdi = 0; vc_v = 2'b01; flit_cnt = 2'b11;
    @(negedge tlx_clk);
    resp_v = 0; vc_v = 2'b00; flit_cnt = 2'b00;
    checks++; if (resp_full !== 1'b0) $display("FAIL full_clear got %b exp 0", resp_full); else passed++;
    ctl_req(4'd4);
    checks++; if (ind !== 8'h0A) $display("FAIL full_order_ind got %h exp 0a", ind); else passed++;
  endtask

  task automatic test_same_cycle();
    do_reset();
    push1(0); push1(1); push1(1); push1(1);
    grant(2'b10, 2'b10);
    grant(2'b10, 2'b01);
    ctl = 1; rl = 4'd2; vc_v = 2'b10; flit_cnt = 2'b01;
    @(negedge tlx_clk);
    ctl = 0; rl = 4'd0; vc_v = 2'b00; flit_cnt = 2'b00;
    $display("ctl rl=2 + grant vc1 -> v=%b ind=%h", bdi_v, ind);
    checks++; if (bdi_v !== 1'b1) $display("FAIL same_v got %b exp 1", bdi_v); else passed++;
    checks++; if (ind !== 8'h02) $display("FAIL same_ind got %h exp 02", ind); else passed++;
    ctl_req(4'd2);
    checks++; if (ind !== 8'h03) $display("FAIL same_next_ind got %h exp 03", ind); else passed++;
    checks++; if (err !== 1'b0) $display("FAIL same_err got %b exp 0", err); else passed++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    push0(1); push0(0); push0(0); push0(1);
    push0(1); push0(0); push0(1); push0(0);
    grant(2'b01, 2'b11);
    grant(2'b01, 2'b11);
    ctl = 1; rl = 4'd3;
    @(negedge tlx_clk);
    checks++; if (ind !== 8'h01) $display("FAIL b2b_ind0 got %h exp 01", ind); else passed++;
    rl = 4'd3;
    @(negedge tlx_clk);
    checks++; if (bdi_v !== 1'b1) $display("FAIL b2b_v1 got %b exp 1", bdi_v); else passed++;
    checks++; if (ind !== 8'h03) $display("FAIL b2b_ind1 got %h exp 03", ind); else passed++;
    checks++; if (err !== 1'b0) $display("FAIL b2b_err got %b exp 0", err); else passed++;
    rl = 4'd9;
    @(negedge tlx_clk);
    ctl = 0; rl = 4'd0;
    $display("ctl rl=9 -> v=%b ind=%h err=%b", bdi_v, ind, err);
    checks++; if (ind !== 8'hFD) $display("FAIL clamp_ind got %h exp fd", ind); else passed++;
    checks++; if (err !== 1'b1) $display("FAIL clamp_err got %b exp 1", err); else passed++;
    @(negedge tlx_clk);
    checks++; if (bdi_v !== 1'b0) $display("FAIL b2b_end_v got %b exp 0", bdi_v); else passed++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 6; i++) push0(0);
    grant(2'b01, 2'b11);
    grant(2'b01, 2'b10);
    push1(0);
    reset_n = 0; ctl = 1; rl = 4'd2;
    @(negedge tlx_clk);
    reset_n = 1; ctl = 0; rl = 4'd0;
    checks++; if (bdi_v !== 1'b0) $display("FAIL rmid_v_in_reset got %b exp 0", bdi_v); else passed++;
    ctl_req(4'd0);
    checks++; if (bdi_v !== 1'b1) $display("FAIL rmid_v got %b exp 1", bdi_v); else passed++;
    checks++; if (ind !== 8'h00) $display("FAIL rmid_ind got %h exp 00", ind); else passed++;
    checks++; if (err !== 1'b0) $display("FAIL rmid_err got %b exp 0", err); else passed++;
    grant(2'b10, 2'b01);
    ctl_req(4'd1);
    checks++; if (ind !== 8'h01) $display("FAIL rmid_empty_ind got %h exp 01", ind); else passed++;
    checks++; if (err !== 1'b1) $display("FAIL rmid_empty_err got %b exp 1", err); else passed++;
  endtask

  initial begin
    idle();
    reset_n = 0;
    @(negedge tlx_clk);
    test_reset();
    test_basic();
    test_mixed();
    test_underflow();
    test_fifo_full();
    test_same_cycle();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
